// File: rtl/linear_embedding_stream.sv
// rtl/linear_embedding_stream.sv - streaming patch projection to int8 embedding features
module linear_embedding_stream #(
    parameter int NUM_PATCH = 15,
    parameter int PATCH_LEN = 12,
    parameter int EMB_DIM   = 16,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int SHIFT     = 6,
    localparam int DEPTH    = PATCH_LEN*EMB_DIM + EMB_DIM,
    localparam int AW       = $clog2(DEPTH),
    localparam int PW       = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1,
    localparam int DW       = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic              w_we,
    input  logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PW-1:0]     out_patch,
    output logic [DW-1:0]     out_dim,
    output logic              done
);
    localparam int KW = (PATCH_LEN > 1) ? $clog2(PATCH_LEN) : 1;
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] RND  = SW'(2**(SHIFT-1));
    localparam logic signed [SW-1:0] QMAX = SW'(2**(DATA_W-1) - 1);
    localparam logic signed [SW-1:0] QMIN = -QMAX - SW'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, QUANT, DRAIN} state_t;

    state_t                    state, state_n;
    logic [KW-1:0]             k;
    logic [PW-1:0]             patch;
    logic [DW-1:0]             dim;
    logic signed [ACC_W-1:0]   acc   [EMB_DIM];
    logic signed [DATA_W-1:0]  q     [EMB_DIM];
    logic signed [DATA_W-1:0]  q_n   [EMB_DIM];
    logic signed [2*DATA_W-1:0] prod [EMB_DIM];
    logic signed [DATA_W-1:0]  wmem  [DEPTH];
    logic signed [SW-1:0]      sum   [EMB_DIM];
    logic signed [SW-1:0]      shr   [EMB_DIM];
    logic                      in_hs, out_hs, last_k, last_dim, last_patch;

    assign in_hs      = in_valid && (state == ACCUM);
    assign out_hs     = out_ready && (state == DRAIN);
    assign last_k     = (k == KW'(PATCH_LEN-1));
    assign last_dim   = (dim == DW'(EMB_DIM-1));
    assign last_patch = (patch == PW'(NUM_PATCH-1));

    assign out_data  = q[dim];
    assign out_patch = patch;
    assign out_dim   = dim;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_n = ACCUM;
            ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && last_k) state_n = QUANT;
            end
            QUANT: begin
                busy    = 1'b1;
                state_n = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && last_dim) state_n = last_patch ? IDLE : ACCUM;
            end
            default: state_n = IDLE;
        endcase
    end

    // Column k of the weight matrix feeds all EMB_DIM accumulators in parallel
    always_comb begin
        for (int d = 0; d < EMB_DIM; d++) begin
            prod[d] = $signed(in_data) * wmem[AW'(int'(k)*EMB_DIM + d)];
        end
    end

    // Round-half-up shift on widened sum so bias and rounding can never wrap
    always_comb begin
        for (int d = 0; d < EMB_DIM; d++) begin
            sum[d] = SW'(acc[d]) + SW'(wmem[AW'(PATCH_LEN*EMB_DIM + d)]) + RND;
            shr[d] = sum[d] >>> SHIFT;
            if (shr[d] > QMAX)      q_n[d] = QMAX[DATA_W-1:0];
            else if (shr[d] < QMIN) q_n[d] = QMIN[DATA_W-1:0];
            else                    q_n[d] = shr[d][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= '0;
            patch <= '0;
            dim   <= '0;
            done  <= 1'b0;
            for (int d = 0; d < EMB_DIM; d++) begin
                acc[d] <= '0;
                q[d]   <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    k     <= '0;
                    patch <= '0;
                    dim   <= '0;
                end
                ACCUM: if (in_hs) begin
                    for (int d = 0; d < EMB_DIM; d++) begin
                        acc[d] <= ((k == '0) ? '0 : acc[d]) + ACC_W'(prod[d]);
                    end
                    k <= last_k ? '0 : k + KW'(1);
                end
                QUANT: begin
                    for (int d = 0; d < EMB_DIM; d++) q[d] <= q_n[d];
                    dim <= '0;
                end
                DRAIN: if (out_hs) begin
                    if (last_dim) begin
                        dim <= '0;
                        k   <= '0;
                        if (last_patch) done  <= 1'b1;
                        else            patch <= patch + PW'(1);
                    end else begin
                        dim <= dim + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Coefficient memory survives rst so a frame can restart without reloading
    always_ff @(posedge clk) begin
        if ((state == IDLE) && w_we && (int'(w_addr) < DEPTH)) wmem[w_addr] <= w_data;
    end
endmodule

// File: tb/tb_linear_embedding_stream.sv
// tb/tb_linear_embedding_stream.sv - scoreboard bench for linear_embedding_stream
module tb_linear_embedding_stream;
    localparam int NP = 2, PL = 4, ED = 2, SH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, w_we = 1'b0;
    logic [3:0] w_addr = '0;
    logic [7:0] w_data = '0, in_data = '0, out_data;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic       busy, in_ready, out_valid, done;
    logic [0:0] out_patch, out_dim;

    typedef struct { int p; int d; int v; } exp_t;
    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   mw [PL][ED];
    int   mb [ED];

    linear_embedding_stream #(
        .NUM_PATCH(NP), .PATCH_LEN(PL), .EMB_DIM(ED),
        .DATA_W(8), .ACC_W(24), .SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_patch(out_patch), .out_dim(out_dim), .done(done)
    );

    always #5 clk = ~clk;

    task automatic wr(input int addr, input int val);
        @(negedge clk);
        w_we = 1'b1; w_addr = 4'(addr); w_data = 8'(val);
        @(negedge clk);
        w_we = 1'b0;
        if (addr < PL*ED) mw[addr/ED][addr%ED] = val;
        else              mb[addr-PL*ED] = val;
    endtask

    task automatic load_all(input int w, input int b);
        for (int a = 0; a < PL*ED; a++) wr(a, w);
        for (int d = 0; d < ED; d++) wr(PL*ED + d, b);
    endtask

    task automatic start_frame();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Pushes expectations for full patches, then feeds n samples
    task automatic feed(input int p, input int s[PL], input bit gaps, input int n);
        int k, g, acc, r;
        if (n == PL) begin
            for (int d = 0; d < ED; d++) begin
                acc = 0;
                for (int j = 0; j < PL; j++) acc += s[j] * mw[j][d];
                r = (acc + mb[d] + (1 << (SH-1))) >>> SH;
                if (r > 127) r = 127;
                if (r < -128) r = -128;
                sb.push_back('{p, d, r});
            end
        end
        k = 0; g = 0;
        while (k < n && g < 200) begin
            @(negedge clk); g++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1; in_data = 8'(s[k]);
                if (in_ready) k++;
            end
        end
        n_cmp++;
        if (k != n) begin n_bad++; $display("FAIL feed_timeout fed=%0d required=%0d", k, n); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall);
        exp_t e;
        int   g;
        for (int i = 0; i < ED; i++) begin
            g = 0;
            while (!out_valid && g < 50) begin @(negedge clk); g++; end
            n_cmp++;
            if (!out_valid || sb.size() == 0) begin
                n_bad++; $display("FAIL drain_timeout out_valid=%0b queued=%0d", out_valid, sb.size());
                return;
            end
            e = sb.pop_front();
            if (stall > 0 && i == 0) begin
                repeat (stall) begin
                    @(negedge clk);
                    n_cmp++;
                    if (out_data !== 8'(e.v) || out_dim !== 1'(e.d) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stall_hold data=%0d dim=%0d in_ready=%0b valid=%0b required data=%0d dim=%0d",
                                 $signed(out_data), out_dim, in_ready, out_valid, e.v, e.d);
                    end
                end
            end
            n_cmp++;
            if (out_data !== 8'(e.v) || out_patch !== 1'(e.p) || out_dim !== 1'(e.d)) begin
                n_bad++;
                $display("FAIL feature got p%0d d%0d %0d required p%0d d%0d %0d",
                         out_patch, out_dim, $signed(out_data), e.p, e.d, e.v);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic check_done();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL done_pulse done=%0b busy=%0b required 1/0", done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL done_width done=%0b required 0", done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, in_ready, out_valid, done} !== 4'b0 || out_data !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state busy=%0b in_ready=%0b out_valid=%0b done=%0b data=%0d required all 0",
                     busy, in_ready, out_valid, done, out_data);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_no_start in_ready=%0b required 0", in_ready); end
    endtask

    task automatic test_basic();
        load_all(1, 0);
        start_frame();
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL start_latency in_ready=%0b busy=%0b required 1/1", in_ready, busy);
        end
        feed(0, '{4, 4, 4, 4}, 1'b0, PL);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL quant_cycle out_valid=%0b required 0", out_valid); end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL out_latency out_valid=%0b required 1", out_valid); end
        drain(0);
        feed(1, '{1, 2, 3, -1}, 1'b0, PL);
        drain(0);
        check_done();
    endtask

    task automatic test_saturation();
        load_all(127, 0);
        start_frame();
        feed(0, '{127, 127, 127, 127}, 1'b0, PL);
        drain(0);
        feed(1, '{-128, -128, -128, -128}, 1'b0, PL);
        drain(0);
        check_done();
    endtask

    task automatic test_rounding();
        int bias [4] = '{1, -3, -4, -6};
        int s0   [4] = '{1, 1, 2, 1};
        int s1   [4] = '{2, 2, 1, 3};
        load_all(0, 0);
        wr(0, 1);
        for (int i = 0; i < 4; i++) begin
            wr(PL*ED, bias[i]);
            start_frame();
            feed(0, '{s0[i], 0, 0, 0}, 1'b0, PL);
            drain(0);
            feed(1, '{s1[i], 0, 0, 0}, 1'b0, PL);
            drain(0);
            check_done();
        end
    endtask

    task automatic test_backpressure();
        load_all(1, 0);
        start_frame();
        feed(0, '{4, 4, 4, 4}, 1'b1, PL);
        drain(5);
        feed(1, '{1, 2, 3, -1}, 1'b1, PL);
        drain(5);
        check_done();
    endtask

    task automatic test_midframe_reset();
        int bad;
        start_frame();
        feed(0, '{4, 4, 4, 4}, 1'b0, PL);
        drain(0);
        feed(1, '{4, 4, 0, 0}, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL midframe_reset bad_cycles=%0d required 0", bad); end
        start_frame();
        w_we = 1'b1; w_addr = 4'd0; w_data = 8'd99;
        @(negedge clk);
        w_we = 1'b0;
        feed(0, '{4, 4, 4, 4}, 1'b0, PL);
        drain(0);
        feed(1, '{1, 2, 3, -1}, 1'b0, PL);
        drain(0);
        check_done();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_midframe_reset();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_left entries=%0d required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
